// File: rtl/fb_access_arbiter_if.sv
// Writer handshake and frame-buffer RAM bus shared by the arbiter and its environment.
// The slave modport is the arbiter's view. The master modport is the writer/RAM side.
interface fb_access_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
) ();
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: shares the single-port frame-buffer RAM between VGA scan-out
// reads (absolute priority during active video) and one pixel writer.
// The writer is served in the blanking gaps.
// Optional macro FB_VBLANK_ONLY_EN: writes are accepted only during vertical blanking.
module fb_access_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          H_Count_Value,
    input  logic [9:0]          V_Count_Value,
    fb_access_arbiter_if.slave  bus,
    output logic [7:0]          R,
    output logic [7:0]          G,
    output logic [7:0]          B,
    output logic                frame_done,
    output logic                wr_err,
    output logic [15:0]         stall_cnt
);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

    localparam logic [9:0]        H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0]        V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0]        H_LAST       = 10'(H_ACTIVE - 1);
    localparam logic [9:0]        V_LAST       = 10'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LINE_PIXELS  = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] FRAME_PIXELS = ADDR_W'(H_ACTIVE * V_ACTIVE);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wr_err_q, wr_err_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic [1:0]        valid_q;
    logic [DATA_W-1:0] rgb_q;

    logic              scan_req;
    logic              wr_ready;
    logic              at_origin;
    logic [ADDR_W-1:0] scan_addr;

    assign scan_req  = (H_Count_Value < H_ACT) && (V_Count_Value < V_ACT);
    assign at_origin = (H_Count_Value == 10'd0) && (V_Count_Value == 10'd0);
    assign scan_addr = ADDR_W'(V_Count_Value) * LINE_PIXELS + ADDR_W'(H_Count_Value);

`ifdef FB_VBLANK_ONLY_EN
    assign wr_ready = rst_n && (V_Count_Value >= V_ACT);
`else
    assign wr_ready = rst_n && !scan_req;
`endif

    assign bus.wr_ready  = wr_ready;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Grant decision for this cycle and the RAM command it produces.
    always_comb begin
        state_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_err_d    = wr_err_q;
        if (scan_req) begin
            state_d    = SCAN;
            mem_addr_d = scan_addr;
        end else if (bus.wr_valid && wr_ready) begin
            state_d = WRITE;
            if (bus.wr_addr < FRAME_PIXELS) begin
                mem_addr_d  = bus.wr_addr;
                mem_we_d    = 1'b1;
                mem_wdata_d = bus.wr_data;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // Writer stall accounting and end-of-frame detection; the frame-origin clear beats a stall.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        frame_done_d = (H_Count_Value == H_LAST) && (V_Count_Value == V_LAST);
        if (at_origin) begin
            stall_cnt_d = 16'd0;
        end else if (bus.wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Grant state, RAM command registers and sticky/status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            wr_err_q     <= 1'b0;
            stall_cnt_q  <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            wr_err_q     <= wr_err_d;
            stall_cnt_q  <= stall_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pixel pipeline: state_q==SCAN marks the address stage, valid_q[0] the RAM-data stage,
    // valid_q[1] the output stage; an invalid output stage shows blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 2'b00;
            rgb_q   <= '0;
        end else begin
            valid_q <= {valid_q[0], (state_q == SCAN)};
            rgb_q   <= bus.mem_rdata;
        end
    end

    assign R          = valid_q[1] ? rgb_q[23:16] : 8'd0;
    assign G          = valid_q[1] ? rgb_q[15:8]  : 8'd0;
    assign B          = valid_q[1] ? rgb_q[7:0]   : 8'd0;
    assign frame_done = frame_done_q;
    assign wr_err     = wr_err_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb_fb_access_arbiter: drives the VGA counters directly (jumping where convenient),
// models an address-pattern RAM, and scoreboards pixels and RAM commands.
`timescale 1ns/1ps
module tb_fb_access_arbiter;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int ADDR_W       = 19;
    localparam int DATA_W       = 24;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic [7:0]  rOut, gOut, bOut;
    logic        frameDone;
    logic        wrErr;
    logic [15:0] stallCnt;

    fb_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_access_arbiter #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .H_Count_Value(hCount), .V_Count_Value(vCount),
        .bus(bus),
        .R(rOut), .G(gOut), .B(bOut),
        .frame_done(frameDone), .wr_err(wrErr), .stall_cnt(stallCnt)
    );

    // Pixel clock.
    always #5 clk = ~clk;

    // Address-pattern RAM: bit 23 set so every scanned pixel is nonzero.
    function automatic logic [23:0] pattern(input logic [ADDR_W-1:0] a);
        return {5'b10000, a};
    endfunction

    // One-cycle synchronous read.
    always @(posedge clk) bus.mem_rdata <= pattern(bus.mem_addr);

    int unsigned checks = 0;
    int unsigned passed = 0;

    int unsigned       mStall;
    bit                mErr;
    bit                mWe;
    bit                mFd;
    logic [ADDR_W-1:0] mAddr;
    logic [23:0]       mWdata;
    logic [23:0]       pixQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        else
            passed++;
    endtask

    function automatic bit modelReady(input int h, input int v);
`ifdef FB_VBLANK_ONLY_EN
        return v >= V_ACTIVE;
`else
        return !((h < H_ACTIVE) && (v < V_ACTIVE));
`endif
    endfunction

    task automatic resetModel();
        mStall = 0;
        mErr   = 1'b0;
        mWe    = 1'b0;
        mFd    = 1'b0;
        mAddr  = '0;
        mWdata = '0;
        pixQ.delete();
        pixQ.push_back(24'h0);
        pixQ.push_back(24'h0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rgb"},        32'({rOut, gOut, bOut}), 32'h0);
        checkOutput({tag, "_mem_addr"},   32'(bus.mem_addr), 32'h0);
        checkOutput({tag, "_mem_we"},     32'(bus.mem_we), 32'h0);
        checkOutput({tag, "_mem_wdata"},  32'(bus.mem_wdata), 32'h0);
        checkOutput({tag, "_frame_done"}, 32'(frameDone), 32'h0);
        checkOutput({tag, "_wr_err"},     32'(wrErr), 32'h0);
        checkOutput({tag, "_stall_cnt"},  32'(stallCnt), 32'h0);
        checkOutput({tag, "_wr_ready"},   32'(bus.wr_ready), 32'h0);
    endtask

    // Drive one cycle of counters/writer inputs, predict, clock, then compare everything.
    task automatic applyStimulus(input int h, input int v, input bit wv, input int wa,
                                 input logic [23:0] wd, output bit rdy);
        bit scan;
        bit mRdy;
        hCount       = 10'(h);
        vCount       = 10'(v);
        bus.wr_valid = wv;
        bus.wr_addr  = ADDR_W'(wa);
        bus.wr_data  = wd;
        #1;
        rdy  = bus.wr_ready;
        scan = (h < H_ACTIVE) && (v < V_ACTIVE);
        mRdy = modelReady(h, v);
        checkOutput("wr_ready", 32'(rdy), 32'(mRdy));
        pixQ.push_back(scan ? pattern(ADDR_W'(v * H_ACTIVE + h)) : 24'h0);
        mWe = 1'b0;
        mFd = (h == H_ACTIVE - 1) && (v == V_ACTIVE - 1);
        if (scan) begin
            mAddr = ADDR_W'(v * H_ACTIVE + h);
        end else if (wv && mRdy) begin
            if (wa < FRAME_PIXELS) begin
                mAddr  = ADDR_W'(wa);
                mWe    = 1'b1;
                mWdata = wd;
            end else begin
                mErr = 1'b1;
            end
        end
        if (h == 0 && v == 0) mStall = 0;
        else if (wv && !mRdy && mStall < 32'hFFFF) mStall++;
        @(posedge clk);
        #1;
        checkOutput("pixel",      32'({rOut, gOut, bOut}), 32'(pixQ.pop_front()));
        checkOutput("mem_we",     32'(bus.mem_we), 32'(mWe));
        checkOutput("mem_addr",   32'(bus.mem_addr), 32'(mAddr));
        checkOutput("mem_wdata",  32'(bus.mem_wdata), 32'(mWdata));
        checkOutput("frame_done", 32'(frameDone), 32'(mFd));
        checkOutput("stall_cnt",  32'(stallCnt), 32'(mStall));
        checkOutput("wr_err",     32'(wrErr), 32'(mErr));
    endtask

    typedef struct {
        int          h;
        int          v;
        bit          wv;
        int          wa;
        logic [23:0] wd;
        bit          expReady;
        bit          expReadyVb;
    } vec_t;

    vec_t vecs[10];

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit rdy;
        int h;

        vecs[0] = '{639,   0, 1'b0,      0, 24'h000000, 1'b0, 1'b0};
        vecs[1] = '{640,   0, 1'b1,      5, 24'h111111, 1'b1, 1'b0};
        vecs[2] = '{799, 100, 1'b1,   2000, 24'h222222, 1'b1, 1'b0};
        vecs[3] = '{  0, 479, 1'b1,   3000, 24'h2B2B2B, 1'b0, 1'b0};
        vecs[4] = '{639, 479, 1'b0,      0, 24'h000000, 1'b0, 1'b0};
        vecs[5] = '{640, 479, 1'b0,      0, 24'h000000, 1'b1, 1'b0};
        vecs[6] = '{  0, 480, 1'b1, 307199, 24'h333333, 1'b1, 1'b1};
        vecs[7] = '{799, 524, 1'b1,      4, 24'h444444, 1'b1, 1'b1};
        vecs[8] = '{  0,   0, 1'b0,      0, 24'h000000, 1'b0, 1'b0};
        vecs[9] = '{  5,   3, 1'b0,      0, 24'h000000, 1'b0, 1'b0};

        rst_n        = 1'b0;
        hCount       = 10'd0;
        vCount       = 10'd0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkReset("init");
        resetModel();
        rst_n = 1'b1;

        // Full line 0: first pixel 3 cycles after release, (639,0) 639 later, blank from H=640.
        for (int x = 0; x < 800; x++) applyStimulus(x, 0, 1'b0, 0, 24'h0, rdy);

        // Boundary vectors.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].h, vecs[i].v, vecs[i].wv, vecs[i].wa, vecs[i].wd, rdy);
`ifdef FB_VBLANK_ONLY_EN
            checkOutput("vec_ready", 32'(rdy), 32'(vecs[i].expReadyVb));
`else
            checkOutput("vec_ready", 32'(rdy), 32'(vecs[i].expReady));
`endif
        end

        // Writer held through active video until a gap opens.
        applyStimulus(0, 0, 1'b0, 0, 24'h0, rdy);
`ifdef FB_VBLANK_ONLY_EN
        for (int x = 700; x < 800; x++) applyStimulus(x, 5, 1'b1, 1000, 24'hA5A5A5, rdy);
        for (int x = 0; x < 4; x++)     applyStimulus(x, 6, 1'b1, 1000, 24'hA5A5A5, rdy);
        for (int x = 796; x < 800; x++) applyStimulus(x, 479, 1'b1, 1000, 24'hA5A5A5, rdy);
        checkOutput("vb_wait_ready", 32'(rdy), 32'h0);
        applyStimulus(0, 480, 1'b1, 1000, 24'hA5A5A5, rdy);
        checkOutput("vb_xfer_ready", 32'(rdy), 32'h1);
        checkOutput("vb_xfer_we",    32'(bus.mem_we), 32'h1);
        checkOutput("vb_xfer_addr",  32'(bus.mem_addr), 32'd1000);
        checkOutput("vb_stall_cnt",  32'(stallCnt), 32'd108);
`else
        h = 100;
        do begin
            applyStimulus(h, 10, 1'b1, 1000, 24'hA5A5A5, rdy);
            h++;
        end while (!rdy && h < 800);
        checkOutput("write_h",     32'(h - 1), 32'd640);
        checkOutput("write_we",    32'(bus.mem_we), 32'h1);
        checkOutput("write_addr",  32'(bus.mem_addr), 32'd1000);
        checkOutput("write_wdata", 32'(bus.mem_wdata), 32'hA5A5A5);
        checkOutput("write_stall", 32'(stallCnt), 32'd540);
`endif
        applyStimulus(641, 10, 1'b0, 0, 24'h0, rdy);

        // Out-of-range write during vertical blanking: acknowledged, dropped, sticky error.
        applyStimulus(10, 490, 1'b1, 307200, 24'h123456, rdy);
        checkOutput("oor_ready", 32'(rdy), 32'h1);
        checkOutput("oor_we",    32'(bus.mem_we), 32'h0);
        checkOutput("oor_err",   32'(wrErr), 32'h1);
        applyStimulus(11, 490, 1'b0, 0, 24'h0, rdy);

        // End of frame: one pulse, the edge after (639,479).
        for (int x = 636; x < 643; x++) begin
            applyStimulus(x, 479, 1'b0, 0, 24'h0, rdy);
            checkOutput("frame_done_pulse", 32'(frameDone), 32'(x == 639));
        end
        checkOutput("err_sticky", 32'(wrErr), 32'h1);

        // Asynchronous reset in mid-frame, held for 2 cycles, then resume scan-out.
        for (int x = 290; x < 300; x++) applyStimulus(x, 200, 1'b0, 0, 24'h0, rdy);
        hCount = 10'd300;
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async_reset");
        @(posedge clk);
        #1;
        hCount = 10'd301;
        @(posedge clk);
        #1;
        checkReset("reset_hold");
        resetModel();
        rst_n = 1'b1;
        for (int x = 302; x < 320; x++) applyStimulus(x, 200, 1'b0, 0, 24'h0, rdy);
        checkOutput("resume_pixel", 32'({rOut, gOut, bOut}), 32'(pattern(ADDR_W'(200 * H_ACTIVE + 317))));

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
